// File: rtl/mem_wait_stage_pkg.sv
// Shared constants for the memory-wait stage: ld_op layout, size codes,
// FSM encoding and bus-width helpers.
package mem_wait_stage_pkg;

  // ld_op field layout: [3] load, [2] unsigned, [1:0] size
  localparam int LD_LOAD_BIT = 3;
  localparam int LD_UNS_BIT  = 2;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // fixed field widths
  localparam int PC_W    = 32;
  localparam int VADDR_W = 32;
  localparam int DEST_W  = 5;
  localparam int LD_OP_W = 4;

  // {pc, rf_wdata, gr_we, dest, ld_op, vaddr, ex, mem_req, side}
  function automatic int em_bus_w(input int data_w, input int side_w);
    return PC_W + data_w + 1 + DEST_W + LD_OP_W + VADDR_W + 1 + 1 + side_w;
  endfunction

  // {pc, final_result, gr_we, dest, vaddr, ex, side}
  function automatic int mw_bus_w(input int data_w, input int side_w);
    return PC_W + data_w + 1 + DEST_W + VADDR_W + 1 + side_w;
  endfunction

  // {fwd_dest, fwd_data, fwd_pending}
  function automatic int md_bus_w(input int data_w);
    return DEST_W + data_w + 1;
  endfunction

  // number of address bits selecting a byte lane within one data word
  function automatic int lane_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_wait_stage_load_align.sv
// load_align: picks the addressed lane out of a returned data word and
// zero/sign-extends it to DATA_W according to ld_op.
module load_align
  import mem_wait_stage_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int OFF_W  = lane_w(DATA_W)
) (
  input  logic [DATA_W-1:0]  rdata,
  input  logic [OFF_W-1:0]   lane,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [DATA_W-1:0]  data
);

  localparam int SHW = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0]        shifted;
  logic [DATA_W-1:0]        left;
  logic [DATA_W-1:0]        zext;
  logic signed [DATA_W-1:0] sext;
  logic [SHW-1:0]           sh;

  // sh = DATA_W minus the access width; dword folds to word on 32-bit data
  always_comb begin
    sh = SHW'(DATA_W - 32);
    case (ld_op[1:0])
      SZ_BYTE:  sh = SHW'(DATA_W - 8);
      SZ_HALF:  sh = SHW'(DATA_W - 16);
      SZ_WORD:  sh = SHW'(DATA_W - 32);
      default:  sh = (DATA_W == 64) ? SHW'(0) : SHW'(DATA_W - 32);
    endcase
  end

  // bring the lane to bit 0, park the field at the MSB, then shift back
  // logically or arithmetically to get the extension for free
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    left    = shifted << sh;
    zext    = left >> sh;
    sext    = $signed(left) >>> sh;
    data    = ld_op[LD_UNS_BIT] ? zext : sext;
  end

endmodule

// File: rtl/mem_wait_stage.sv
// mem_wait_stage: holds one instruction between EX and WB, waits for the
// data SRAM response when it issued a request, aligns load data and drops
// responses belonging to flushed requests.
module mem_wait_stage
  import mem_wait_stage_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  SIDE_W      = 80,
  parameter int  FLUSH_CNT_W = 2,
  localparam int EM_W        = em_bus_w(DATA_W, SIDE_W),
  localparam int MW_W        = mw_bus_w(DATA_W, SIDE_W),
  localparam int MD_W        = md_bus_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              EM_valid,
  input  logic [EM_W-1:0]   EM_BUS,
  output logic              M_allowin,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              ex_en,
  input  logic              W_allowin,
  output logic              MW_valid,
  output logic [MW_W-1:0]   MW_BUS,
  output logic [MD_W-1:0]   MD_for_BUS
);

  localparam int OFF_W = lane_w(DATA_W);
  localparam logic [FLUSH_CNT_W-1:0] STALE_MAX = '1;

  // unpacked upstream fields
  logic [PC_W-1:0]    in_pc;
  logic [DATA_W-1:0]  in_rf_wdata;
  logic               in_gr_we;
  logic [DEST_W-1:0]  in_dest;
  logic [LD_OP_W-1:0] in_ld_op;
  logic [VADDR_W-1:0] in_vaddr;
  logic               in_ex;
  logic               in_mem_req;
  logic [SIDE_W-1:0]  in_side;

  assign {in_pc, in_rf_wdata, in_gr_we, in_dest, in_ld_op,
          in_vaddr, in_ex, in_mem_req, in_side} = EM_BUS;

  // stage registers
  logic [1:0]             state, state_nxt;
  logic [FLUSH_CNT_W-1:0] stale_cnt;
  logic [PC_W-1:0]        pc_q;
  logic [DATA_W-1:0]      rf_wdata_q;
  logic                   gr_we_q;
  logic [DEST_W-1:0]      dest_q;
  logic [LD_OP_W-1:0]     ld_op_q;
  logic [VADDR_W-1:0]     vaddr_q;
  logic                   ex_q;
  logic [SIDE_W-1:0]      side_q;
  logic [DATA_W-1:0]      rdata_q;

  logic              accept;
  logic              stale_any;
  logic              resp_take;
  logic              stale_inc;
  logic              stale_dec;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  assign stale_any = (stale_cnt != '0);

  // a stale response must drain before any new request can be issued
  assign M_allowin = !stale_any &&
                     ((state == ST_IDLE) || ((state == ST_FULL) && W_allowin));

  // an instruction arriving under a flush belongs to the flushed path
  assign accept = EM_valid && M_allowin && !ex_en;

  // the response in WAIT belongs to us only when nothing stale is ahead
  assign resp_take = (state == ST_WAIT) && data_sram_data_ok && !stale_any;

  // a flush while still waiting leaves one response in flight to discard
  assign stale_inc = (state == ST_WAIT) && ex_en && !data_sram_data_ok;
  assign stale_dec = stale_any && data_sram_data_ok;

  // next-state: flush wins, otherwise fill, complete or drain
  always_comb begin
    state_nxt = state;
    if (ex_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept)
            state_nxt = (in_mem_req && !in_ex) ? ST_WAIT : ST_FULL;
        end
        ST_WAIT: begin
          if (resp_take)
            state_nxt = ST_FULL;
        end
        ST_FULL: begin
          if (W_allowin) begin
            if (accept)
              state_nxt = (in_mem_req && !in_ex) ? ST_WAIT : ST_FULL;
            else
              state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // stale-response counter, saturating in both directions
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stale_cnt <= '0;
    end else if (stale_inc && !stale_dec) begin
      if (stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + 1'b1;
    end else if (stale_dec && !stale_inc) begin
      stale_cnt <= stale_cnt - 1'b1;
    end
  end

  // instruction payload, loaded only on acceptance so it holds under stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= '0;
      rf_wdata_q <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
      ld_op_q    <= '0;
      vaddr_q    <= '0;
      ex_q       <= 1'b0;
      side_q     <= '0;
    end else if (accept) begin
      pc_q       <= in_pc;
      rf_wdata_q <= in_rf_wdata;
      gr_we_q    <= in_gr_we;
      dest_q     <= in_dest;
      ld_op_q    <= in_ld_op;
      vaddr_q    <= in_vaddr;
      ex_q       <= in_ex;
      side_q     <= in_side;
    end
  end

  // response holding register, written in the data_ok cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          rdata_q <= '0;
    else if (resp_take) rdata_q <= data_sram_rdata;
  end

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata (rdata_q),
    .lane  (vaddr_q[OFF_W-1:0]),
    .ld_op (ld_op_q),
    .data  (load_data)
  );

  assign final_result = ld_op_q[LD_LOAD_BIT] ? load_data : rf_wdata_q;

  assign MW_valid = (state == ST_FULL);
  assign MW_BUS   = {pc_q, final_result, gr_we_q, dest_q, vaddr_q, ex_q, side_q};

  // forwarding: dest only while occupied, pending while a load is in flight
  assign MD_for_BUS = {((state != ST_IDLE) && gr_we_q) ? dest_q : {DEST_W{1'b0}},
                       final_result,
                       (state == ST_WAIT) && ld_op_q[LD_LOAD_BIT]};

endmodule
